// File: rtl/sync_status_fifo.sv
// sync_status_fifo: single-clock FIFO that reports its occupancy (level,
// full, empty, almost_full, almost_empty) and keeps sticky overflow and
// underflow flags.
// Optional build macro SYNC_STATUS_FIFO_FWFT_EN switches read_data to
// first-word-fall-through. Without the macro, read_data is registered and
// updates one cycle after a pop.
// The flags are decoded from the registered level only, so no input has a
// combinational path to them.
module sync_status_fifo #(
    parameter int DATA_WIDTH         = 4,
    parameter int ADDRESS_WIDTH      = 5,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    input  logic                     read_increment,
    input  logic                     clear_errors,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int LW    = ADDRESS_WIDTH + 1;
    localparam int AW    = ADDRESS_WIDTH;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL_LEVEL);
    localparam logic [LW-1:0] LVL_AE   = LW'(ALMOST_EMPTY_LEVEL);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc;
    logic          rd_acc;

    assign level        = level_q;
    assign full         = (level_q == LVL_FULL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Work out which accesses are accepted, then the next pointers, level and error flags.
    // Because the pointers are exactly ADDRESS_WIDTH bits, they wrap naturally at DEPTH.
    // The level counter is what separates a full FIFO from an empty one.
    always_comb begin
        wr_acc      = write_increment & ~full;
        rd_acc      = read_increment & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Setting a flag takes priority over clear_errors on the same edge.
        if (write_increment & full)  overflow_d = 1'b1;
        else if (clear_errors)       overflow_d = 1'b0;

        if (read_increment & empty)  underflow_d = 1'b1;
        else if (clear_errors)       underflow_d = 1'b0;
    end

    // Register the pointers, the level and the sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The storage array is deliberately left out of reset.
    // empty=1 after reset, so stale words cannot be read.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= write_data;
    end

`ifdef SYNC_STATUS_FIFO_FWFT_EN
    // The head word shows on read_data whenever the FIFO holds data.
    // It is forced to zero while empty, so reset also clears it at once.
    assign read_data = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Capture the head word on an accepted pop; hold the value otherwise.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign read_data = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_status_fifo.sv
// Randomised and directed bench for sync_status_fifo.
// A queue-based reference model in this file supplies every expected value.
module tb_sync_status_fifo;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFL   = 28;
    localparam int AEL   = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] write_data;
    logic          write_increment;
    logic          read_increment;
    logic          clear_errors;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    sync_status_fifo #(
        .DATA_WIDTH         (DW),
        .ADDRESS_WIDTH      (AW),
        .ALMOST_FULL_LEVEL  (AFL),
        .ALMOST_EMPTY_LEVEL (AEL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_data      (write_data),
        .write_increment (write_increment),
        .read_increment  (read_increment),
        .clear_errors    (clear_errors),
        .read_data       (read_data),
        .full            (full),
        .empty           (empty),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .level           (level),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q_m [$];
    logic [DW-1:0] rd_m;
    logic          ovf_m;
    logic          unf_m;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        rd_m  = '0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = q_m.size();
        chk_val("level", 32'(level), 32'(n));
        chk_val("full", 32'(full), 32'(n == DEPTH));
        chk_val("empty", 32'(empty), 32'(n == 0));
        chk_val("almost_full", 32'(almost_full), 32'(n >= AFL));
        chk_val("almost_empty", 32'(almost_empty), 32'(n <= AEL));
        chk_val("overflow", 32'(overflow), 32'(ovf_m));
        chk_val("underflow", 32'(underflow), 32'(unf_m));
`ifdef SYNC_STATUS_FIFO_FWFT_EN
        if (n != 0) chk_val("read_data", 32'(read_data), 32'(q_m[0]));
`else
        chk_val("read_data", 32'(read_data), 32'(rd_m));
`endif
    endtask

    // One clock: drive the inputs, take the edge, update the model, then check.
    task automatic step(input logic wi, input logic ri, input logic ce, input logic [DW-1:0] wd);
        int  n;
        bit  m_full;
        bit  m_empty;
        logic [DW-1:0] popped;
        write_increment = wi;
        read_increment  = ri;
        clear_errors    = ce;
        write_data      = wd;
        @(posedge clk);
        n       = q_m.size();
        m_full  = (n == DEPTH);
        m_empty = (n == 0);
        if (wi && m_full)  ovf_m = 1'b1;
        else if (ce)       ovf_m = 1'b0;
        if (ri && m_empty) unf_m = 1'b1;
        else if (ce)       unf_m = 1'b0;
        if (ri && !m_empty) begin
            popped = q_m.pop_front();
            rd_m   = popped;
        end
        if (wi && !m_full) q_m.push_back(wd);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic go_to_level(input int target);
        int guard;
        guard = 0;
        while (q_m.size() < target && guard < 100) begin
            step(1'b1, 1'b0, 1'b0, DW'($urandom));
            guard++;
        end
        while (q_m.size() > target && guard < 100) begin
            step(1'b0, 1'b1, 1'b0, '0);
            guard++;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        write_data      = '0;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        clear_errors    = 1'b0;
        model_reset();
        #1;
        check_all();
        chk_val("reset_read_data", 32'(read_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..F,0,... until full, then drain and compare the order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i + 1));
        chk_val("fill_full", 32'(full), 32'h1);
        chk_val("fill_level", 32'(level), 32'd32);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_STATUS_FIFO_FWFT_EN
            chk_val("drain_data", 32'(read_data), 32'((i + 1) % 16));
            step(1'b0, 1'b1, 1'b0, '0);
`else
            step(1'b0, 1'b1, 1'b0, '0);
            chk_val("drain_data", 32'(read_data), 32'((i + 1) % 16));
`endif
        end
        chk_val("drain_empty", 32'(empty), 32'h1);

        // Threshold edges.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0, DW'($urandom));
            chk_val("ae_step", 32'(almost_empty), 32'(k <= AEL));
        end
        go_to_level(27);
        chk_val("af_27", 32'(almost_full), 32'h0);
        step(1'b1, 1'b0, 1'b0, DW'($urandom));
        chk_val("af_28", 32'(almost_full), 32'h1);

        // Simultaneous read and write at the full and empty boundaries.
        go_to_level(DEPTH);
        step(1'b1, 1'b1, 1'b0, DW'($urandom));
        chk_val("full_rw_level", 32'(level), 32'd31);
        chk_val("full_rw_ovf", 32'(overflow), 32'h1);
        go_to_level(0);
        step(1'b1, 1'b1, 1'b0, DW'($urandom));
        chk_val("empty_rw_level", 32'(level), 32'd1);
        chk_val("empty_rw_unf", 32'(underflow), 32'h1);
        step(1'b0, 1'b0, 1'b1, '0);
        chk_val("clr_ovf", 32'(overflow), 32'h0);
        chk_val("clr_unf", 32'(underflow), 32'h0);

        // A set on the same edge as clear_errors must win.
        go_to_level(DEPTH);
        step(1'b1, 1'b0, 1'b1, DW'($urandom));
        chk_val("set_prio_ovf", 32'(overflow), 32'h1);
        step(1'b0, 1'b0, 1'b1, '0);

        // Pointer wrap with the level held at 3.
        go_to_level(3);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom));
        chk_val("wrap_level", 32'(level), 32'd3);

        // Random traffic in blocks with varying bias to visit both ends.
        for (int blk = 0; blk < 8; blk++) begin
            int pw;
            pw = (blk % 2 == 0) ? 70 : 30;
            for (int i = 0; i < 200; i++)
                step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < 100 - pw),
                     1'($urandom_range(0, 15) == 0), DW'($urandom));
        end

        // Reset in the middle of operation.
        go_to_level(17);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk_val("rst_mid_level", 32'(level), 32'h0);
        chk_val("rst_mid_empty", 32'(empty), 32'h1);
        chk_val("rst_mid_rdata", 32'(read_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 4'hA);
`ifdef SYNC_STATUS_FIFO_FWFT_EN
        chk_val("post_rst_fwft", 32'(read_data), 32'hA);
        step(1'b0, 1'b1, 1'b0, '0);
`else
        step(1'b0, 1'b1, 1'b0, '0);
        chk_val("post_rst_read", 32'(read_data), 32'hA);
`endif
        chk_val("post_rst_empty", 32'(empty), 32'h1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_status_fifo.md
SYNC_STATUS_FIFO -- requirements
Module: sync_status_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, word width in bits (1..32).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, depth DEPTH = 2^ADDRESS_WIDTH words (2..8).
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default 28, level at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have parameter ALMOST_EMPTY_LEVEL, default 4, level at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 SHALL have port clk, input, 1, single clock for all state; rising edge active.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port write_data, input, DATA_WIDTH, word to push.
REQ-008 SHALL have port write_increment, input, 1, push request.
REQ-009 SHALL have port read_increment, input, 1, pop request.
REQ-010 SHALL have port clear_errors, input, 1, synchronous clear of sticky error flags.
REQ-011 SHALL have port read_data, output, DATA_WIDTH, popped or head word.
REQ-012 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, occupancy flags.
REQ-013 SHALL have port level, output, ADDRESS_WIDTH+1, current occupancy 0..DEPTH.
REQ-014 SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-015 SHALL accept a write on a clk edge when write_increment=1 and full=0: mem[write_pointer] <= write_data; write_pointer increments.
REQ-016 SHALL accept a read on a clk edge when read_increment=1 and empty=0; read_pointer increments.
REQ-017 SHALL wrap both pointers modulo DEPTH with no dead entry, so all DEPTH words are usable.
REQ-018 SHALL update level by +1 on write-only, -1 on read-only, and 0 on simultaneous accepted write and read.
REQ-019 SHALL, when full, accept a simultaneous read and reject the write; level ends at DEPTH-1 and overflow sets.
REQ-020 SHALL, when empty, accept a simultaneous write and reject the read; level ends at 1 and underflow sets.
REQ-021 SHALL decode full=(level==DEPTH), empty=(level==0), almost_full=(level>=ALMOST_FULL_LEVEL) and almost_empty=(level<=ALMOST_EMPTY_LEVEL) from the registered level only, with no combinational path from any input.
REQ-022 SHALL set overflow on any edge with write_increment=1 and full=1, and hold it until clear_errors.
REQ-023 SHALL set underflow on any edge with read_increment=1 and empty=1, and hold it until clear_errors.
REQ-024 SHALL give set priority over clear_errors on the same edge; the FIFO contents and pointers are unaffected by either event.
REQ-025 SHALL never corrupt stored data or pointers on a rejected access.
REQ-026 SHALL, in default mode, register read_data <= mem[read_pointer] on an accepted read, valid the cycle after the pop (1-cycle latency), and hold it otherwise.

Reset
REQ-027 SHALL, while rst_n=0, immediately force pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0 and read_data=0.
REQ-028 SHALL leave memory contents unreset; after reset no stale word is readable because empty=1.
REQ-029 SHALL, on reset assertion mid-operation, discard all stored words; the first edge after rst_n rises obeys REQ-015..REQ-026.

Configuration
REQ-030 SHALL, when macro SYNC_STATUS_FIFO_FWFT_EN is defined, operate first-word-fall-through: read_data = mem[read_pointer] combinationally whenever empty=0; a word written into an empty FIFO appears one edge after the write; read_increment pops with 0-cycle latency.
REQ-031 SHALL, when SYNC_STATUS_FIFO_FWFT_EN is undefined, use the registered read of REQ-026; all flags, level and error behaviour are identical in both modes.

Verification
REQ-032 SHALL cover fill/drain: write 0x1..0x0 cycling 32 times, reaching full=1 and level=32 -> 32 reads return the same sequence, ending with empty=1.
REQ-033 SHALL cover thresholds: level stepped 3->4->5 and 27->28 -> almost_empty 1,1,0 and almost_full 0->1 exactly at those edges.
REQ-034 SHALL cover boundary simultaneity: at full, read+write -> level=31, overflow=1; at empty, read+write -> level=1, underflow=1; then clear_errors=1 -> both flags 0.
REQ-035 SHALL cover wrap: 100 interleaved write/read pairs at level 3 -> data order preserved across pointer wrap, level constant 3.
REQ-036 SHALL cover reset mid-operation: rst_n=0 at level 17 -> same-cycle empty=1, level=0, read_data=0; then write 0xA and read -> 0xA (next cycle without FWFT, immediately after write edge with FWFT).
